// File: rtl/accum_n_bits_ctrl.sv
// Go-triggered N-bit accumulator (add/sub/load/clear) with flags, op count, hex display.
// Ports: Clk, Resetn, x, mode, go -> q, carry, overflow, done, ops, hex. Macro: ACCUM_SAT_EN.
module accum_n_bits_ctrl #(
  parameter int N = 8,
  parameter int D = N / 4
) (
  input  logic           Clk,
  input  logic           Resetn,
  input  logic [N-1:0]   x,
  input  logic [1:0]     mode,
  input  logic           go,
  output logic [N-1:0]   q,
  output logic           carry,
  output logic           overflow,
  output logic           done,
  output logic [7:0]     ops,
  output logic [7*D-1:0] hex
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]   state;
  logic [1:0]   mr;
  logic [N-1:0] xr;
  logic [N:0]   sum;
  logic [N:0]   dif;
  logic [N-1:0] nq;
  logic         nc;
  logic         nv;

  assign sum = {1'b0, q} + {1'b0, xr};
  assign dif = {1'b0, q} - {1'b0, xr};

  always_comb begin
    nq = q;
    nc = carry;
    nv = overflow;
    unique case (1'b1)
      (mr == 2'b00): begin
        nq = sum[N-1:0];
        nc = sum[N];
        nv = (q[N-1] == xr[N-1]) && (sum[N-1] != q[N-1]);
`ifdef ACCUM_SAT_EN
        if (sum[N]) nq = '1;
`endif
      end
      (mr == 2'b01): begin
        nq = dif[N-1:0];
        nc = dif[N];
        nv = (q[N-1] != xr[N-1]) && (dif[N-1] != q[N-1]);
`ifdef ACCUM_SAT_EN
        if (dif[N]) nq = '0;
`endif
      end
      (mr == 2'b10): begin
        nq = xr;
        nc = 1'b0;
        nv = 1'b0;
      end
      default: begin
        nq = '0;
        nc = 1'b0;
        nv = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      mr       <= 2'b00;
      xr       <= '0;
      q        <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      ops      <= 8'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            mr    <= mode;
            xr    <= x;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          q        <= nq;
          carry    <= nc;
          overflow <= nv;
          done     <= 1'b1;
          if (ops != 8'hFF) ops <= ops + 8'd1;
          state    <= S_HOLD;
        end
        S_HOLD: begin
          if (!go) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] on;
    unique case (v)
      4'h0: on = 7'b1111110;
      4'h1: on = 7'b0110000;
      4'h2: on = 7'b1101101;
      4'h3: on = 7'b1111001;
      4'h4: on = 7'b0110011;
      4'h5: on = 7'b1011011;
      4'h6: on = 7'b1011111;
      4'h7: on = 7'b1110000;
      4'h8: on = 7'b1111111;
      4'h9: on = 7'b1111011;
      4'hA: on = 7'b1110111;
      4'hB: on = 7'b0011111;
      4'hC: on = 7'b1001110;
      4'hD: on = 7'b0111101;
      4'hE: on = 7'b1001111;
      default: on = 7'b1000111;
    endcase
    return ~on;
  endfunction

  for (genvar k = 0; k < D; k++) begin : g_hex
    assign hex[7*k+6:7*k] = seg7(q[4*k+3:4*k]);
  end

endmodule

// File: tb/tb_accum_n_bits_ctrl.sv
// Randomized + directed bench for accum_n_bits_ctrl against an arithmetic model.
// Covers N=8 operations, go hold, reset abort, ops saturation and N=16 hex.
module tb_accum_n_bits_ctrl;

  logic        Clk = 1'b0;
  logic        Resetn = 1'b0;
  logic [7:0]  x = '0;
  logic [1:0]  mode = '0;
  logic        go = 1'b0;
  logic [7:0]  q;
  logic        carry;
  logic        overflow;
  logic        done;
  logic [7:0]  ops;
  logic [13:0] hex;

  logic [15:0] x2 = '0;
  logic [1:0]  mode2 = '0;
  logic        go2 = 1'b0;
  logic [15:0] q2;
  logic        carry2;
  logic        overflow2;
  logic        done2;
  logic [7:0]  ops2;
  logic [27:0] hex2;

  always #5 Clk = ~Clk;

  accum_n_bits_ctrl #(.N(8), .D(2)) dut (
    .Clk(Clk), .Resetn(Resetn), .x(x), .mode(mode), .go(go),
    .q(q), .carry(carry), .overflow(overflow), .done(done),
    .ops(ops), .hex(hex)
  );

  accum_n_bits_ctrl #(.N(16), .D(4)) dut16 (
    .Clk(Clk), .Resetn(Resetn), .x(x2), .mode(mode2), .go(go2),
    .q(q2), .carry(carry2), .overflow(overflow2), .done(done2),
    .ops(ops2), .hex(hex2)
  );

  int checks = 0;
  int errors = 0;
  int qm = 0;
  int cm = 0;
  int vm = 0;
  int opsm = 0;

  string glyph[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                       "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                       "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg(input int v);
    logic [6:0] on;
    string s;
    on = '0;
    s = glyph[v & 15];
    for (int i = 0; i < s.len(); i++) on[6 - (s[i] - 8'h61)] = 1'b1;
    return ~on;
  endfunction

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int m, input int b);
    int a;
    int s;
    a = qm;
    case (m)
      0: begin
        s  = a + b;
        cm = (s > 255) ? 1 : 0;
        s  = sx(a) + sx(b);
        vm = (s > 127 || s < -128) ? 1 : 0;
`ifdef ACCUM_SAT_EN
        qm = cm ? 255 : (a + b) % 256;
`else
        qm = (a + b) % 256;
`endif
      end
      1: begin
        cm = (b > a) ? 1 : 0;
        s  = sx(a) - sx(b);
        vm = (s > 127 || s < -128) ? 1 : 0;
`ifdef ACCUM_SAT_EN
        qm = cm ? 0 : a - b;
`else
        qm = (a - b + 256) % 256;
`endif
      end
      2: begin qm = b; cm = 0; vm = 0; end
      default: begin qm = 0; cm = 0; vm = 0; end
    endcase
    if (opsm < 255) opsm++;
  endtask

  // Issue one operation; optionally scramble mode/x right after capture.
  task automatic run_op(input int m, input int b, input bit scramble,
                        input bit check);
    bit got;
    got = 0;
    mode = m[1:0];
    x = b[7:0];
    go = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge Clk);
      #1;
      if (done) got = 1;
      else if (scramble) begin
        mode = 2'($urandom);
        x = 8'($urandom);
      end
    end
    model(m, b);
    if (check) begin
      chk("done_seen", 32'(got), 32'd1);
      chk("q", 32'(q), 32'(qm));
      chk("carry", 32'(carry), 32'(cm));
      chk("overflow", 32'(overflow), 32'(vm));
      chk("ops", 32'(ops), 32'(opsm));
    end
    @(posedge Clk);
    #1;
    if (check) chk("done_pulse_end", 32'(done), 32'd0);
    go = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int dn;
    bit got;
    #12;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ops", 32'(ops), 32'd0);
    chk("rst_hex", 32'(hex), 32'({seg(0), seg(0)}));
    @(negedge Clk);
    Resetn = 1'b1;
    @(posedge Clk);
    #1;

    run_op(2, 8'h7F, 0, 1);
    run_op(0, 8'h01, 0, 1);
    chk("r31_q", 32'(q), 32'h80);
    chk("r31_ovf", 32'(overflow), 32'd1);
    chk("r31_ops", 32'(ops), 32'd2);
    chk("r31_hex", 32'(hex), 32'({seg(8), seg(0)}));

    run_op(2, 8'hF0, 0, 1);
    run_op(0, 8'h20, 0, 1);
    run_op(2, 8'h05, 0, 1);
    run_op(1, 8'h07, 0, 1);
    run_op(3, 8'h00, 0, 1);

    mode = 2'b00;
    x = 8'h01;
    go = 1'b1;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      #1;
      if (done) dn++;
      mode = 2'($urandom);
      x = 8'($urandom);
    end
    go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      if (done) dn++;
    end
    model(0, 1);
    chk("hold_done_cnt", 32'(dn), 32'd1);
    chk("hold_q", 32'(q), 32'h01);
    chk("hold_ops", 32'(ops), 32'(opsm));

    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1, 1);

    for (int i = 0; i < 8; i++) begin
      chk("hex_rand", 32'(hex), 32'({seg(qm >> 4), seg(qm)}));
      run_op(2, int'($urandom_range(0, 255)), 0, 1);
    end

    mode = 2'b10;
    x = 8'hAA;
    go = 1'b1;
    @(posedge Clk);
    #1;
    Resetn = 1'b0;
    #1;
    go = 1'b0;
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_ops", 32'(ops), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    Resetn = 1'b1;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    chk("abort_q_after", 32'(q), 32'd0);
    qm = 0; cm = 0; vm = 0; opsm = 0;

    for (int i = 0; i < 256; i++)
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 0, 0);
    chk("ops_sat", 32'(ops), 32'd255);
    chk("ops_sat_q", 32'(q), 32'(qm));
    run_op(2, 8'h3C, 0, 1);

    @(negedge Clk);
    Resetn = 1'b0;
    go = 1'b1;
    mode = 2'b10;
    x = 8'h5A;
    @(negedge Clk);
    Resetn = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge Clk);
      #1;
      if (done) got = 1;
    end
    go = 1'b0;
    chk("lvl_go_done", 32'(got), 32'd1);
    chk("lvl_go_q", 32'(q), 32'h5A);
    chk("lvl_go_ops", 32'(ops), 32'd1);

    mode2 = 2'b10;
    x2 = 16'hBEEF;
    go2 = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge Clk);
      #1;
      if (done2) got = 1;
    end
    go2 = 1'b0;
    chk("n16_done", 32'(got), 32'd1);
    chk("n16_q", 32'(q2), 32'hBEEF);
    chk("n16_hex", 32'(hex2),
        32'({seg(11), seg(14), seg(14), seg(15)}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
